pulse_seq_sched: RTL and testbench

- Sequencer that owns the write side of the pulse-generator command FIFO; emits 32-bit command words in the pulse generator's format: [31:24] command, [23:8] coarse, [7:0] fine.
- On start, replays a locally stored table of coarse/fine pulse entries a programmed number of times, preceded by a set-period command and a reset-clock command.
- When idle, forwards single host command words to the FIFO; the scheduler always has priority over the host.

---
 rtl/pulse_seq_sched_if.sv | 20 ++
 rtl/pulse_seq_sched.sv | 188 ++++++++++++++++++
 tb/tb_pulse_seq_sched.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_seq_sched_if.sv
// Host command input and pulse-FIFO write port of the pulse sequencer.
// The sequencer drives the master side; the host/FIFO environment drives the slave side.
interface pulse_seq_sched_if;
    logic [31:0] host_cmd;
    logic        host_valid;
    logic        host_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [31:0] fifo_wdata;

    modport master (
        input  host_cmd, host_valid, fifo_full,
        output host_ready, fifo_wr, fifo_wdata
    );

    modport slave (
        output host_cmd, host_valid, fifo_full,
        input  host_ready, fifo_wr, fifo_wdata
    );
endinterface

// File: rtl/pulse_seq_sched.sv
// Pulse sequence scheduler: replays a stored coarse/fine table into the pulse FIFO,
// preceded by set-period and reset-clock words, and forwards host words when idle.
module pulse_seq_sched #(
    parameter int unsigned AW              = 4,
    parameter logic [7:0]  CMD_RESET_CLOCK = 8'd0,
    parameter logic [7:0]  CMD_SEND_PULSE  = 8'd1,
    parameter logic [7:0]  CMD_SET_PERIOD  = 8'd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_we_i,
    input  logic [AW-1:0]     tbl_addr_i,
    input  logic [23:0]       tbl_wdata_i,
    input  logic [23:0]       period_i,
    input  logic [AW:0]       num_entries_i,
    input  logic [15:0]       repeat_count_i,
    input  logic              start_i,
    input  logic              abort_i,
    pulse_seq_sched_if.master bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [7:0]        state_out_o
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PERIOD = 3'd1,
        RSTCLK = 3'd2,
        ISSUE  = 3'd3,
        FINISH = 3'd4
    } state_e;

    localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

    state_e      state_q;
    logic        wr_pend_q;
    logic [31:0] wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        aborted_q;
    logic        abort_q;
    logic        start_pend_q;
    logic [AW:0] num_q;
    logic [AW:0] idx_q;
    logic [15:0] rep_q;
    logic [15:0] pass_q;
    logic [23:0] tbl_q [2**AW];

    logic          fifo_wr;
    logic          host_ready;
    logic          slot_free;
    logic          start_req;
    logic          abort_eff;
    logic          idx_last;
    logic          pass_last;
    logic          finish_now;
    logic [AW:0]   idx_inc;
    logic [AW-1:0] rd_addr;
    logic [23:0]   tbl_rd;

    assign fifo_wr    = wr_pend_q & ~bus.fifo_full;
    // A new word may be loaded whenever the output register is empty or drains this cycle.
    assign slot_free  = ~wr_pend_q | fifo_wr;
    assign start_req  = (start_i | start_pend_q) & ~abort_i;
    assign host_ready = (state_q == IDLE) & ~start_i & ~start_pend_q & ~bus.fifo_full & ~wr_pend_q;
    assign abort_eff  = abort_q | abort_i;
    assign idx_inc    = idx_q + IDX_ONE;
    assign idx_last   = (idx_q == num_q - IDX_ONE);
    assign pass_last  = (pass_q == rep_q - 16'd1);

    // The word being written decides whether the sequence ends here.
    assign finish_now = busy_q & fifo_wr &
                        (abort_eff |
                         ((state_q == RSTCLK) & ((num_q == '0) | (rep_q == '0))) |
                         ((state_q == ISSUE) & idx_last & pass_last));

    // Look-ahead read: entry 0 when entering ISSUE, otherwise the entry after the current one.
    assign rd_addr = ((state_q == ISSUE) && !idx_last) ? idx_inc[AW-1:0] : '0;
    assign tbl_rd  = tbl_q[rd_addr];

    // NOTE: the table has no reset so it can map onto plain RAM; contents are defined by host writes only.
    always_ff @(posedge clk) begin
        if (tbl_we_i && !busy_q) begin
            tbl_q[tbl_addr_i] <= tbl_wdata_i;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_pend_q    <= 1'b0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_q      <= 1'b0;
            start_pend_q <= 1'b0;
            num_q        <= '0;
            rep_q        <= '0;
            idx_q        <= '0;
            pass_q       <= '0;
        end else begin
            if (fifo_wr) begin
                wr_pend_q <= 1'b0;
            end
            if (busy_q && abort_i) begin
                abort_q <= 1'b1;
            end

            if (finish_now) begin
                state_q   <= FINISH;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                aborted_q <= abort_eff;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_req && slot_free) begin
                            start_pend_q <= 1'b0;
                            busy_q       <= 1'b1;
                            num_q        <= num_entries_i;
                            rep_q        <= repeat_count_i;
                            wr_pend_q    <= 1'b1;
                            wdata_q      <= {CMD_SET_PERIOD, period_i};
                            state_q      <= PERIOD;
                        end else if (start_req) begin
                            start_pend_q <= 1'b1;
                        end else begin
                            start_pend_q <= 1'b0;
                            if (host_ready && bus.host_valid) begin
                                wr_pend_q <= 1'b1;
                                wdata_q   <= bus.host_cmd;
                            end
                        end
                    end
                    PERIOD: begin
                        if (fifo_wr) begin
                            wr_pend_q <= 1'b1;
                            wdata_q   <= {CMD_RESET_CLOCK, 24'h0};
                            state_q   <= RSTCLK;
                        end
                    end
                    RSTCLK: begin
                        if (fifo_wr) begin
                            wr_pend_q <= 1'b1;
                            wdata_q   <= {CMD_SEND_PULSE, tbl_rd};
                            idx_q     <= '0;
                            pass_q    <= '0;
                            state_q   <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (fifo_wr) begin
                            wr_pend_q <= 1'b1;
                            wdata_q   <= {CMD_SEND_PULSE, tbl_rd};
                            if (idx_last) begin
                                idx_q  <= '0;
                                pass_q <= pass_q + 16'd1;
                            end else begin
                                idx_q  <= idx_inc;
                            end
                        end
                    end
                    FINISH: begin
                        done_q    <= 1'b0;
                        aborted_q <= 1'b0;
                        abort_q   <= 1'b0;
                        state_q   <= IDLE;
                    end
                    default: begin
                        busy_q    <= 1'b0;
                        wr_pend_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.fifo_wr    = fifo_wr;
    assign bus.fifo_wdata = wdata_q;
    assign bus.host_ready = host_ready;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign aborted_o      = aborted_q;
    assign state_out_o    = {5'd0, state_q};
endmodule

// File: tb/tb_pulse_seq_sched.sv
// Self-checking bench for pulse_seq_sched: table-driven sequence runs plus hand-written
// stall, abort, host-forwarding and mid-sequence reset cases, checked through a word scoreboard.
`timescale 1ns/1ps
module tb_pulse_seq_sched;
    localparam int AW = 4;

    typedef struct {
        logic [AW:0] num;
        logic [15:0] rep;
        logic [23:0] period;
        int          exp_words;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tbl_we = 1'b0;
    logic [AW-1:0] tbl_addr = '0;
    logic [23:0]   tbl_wdata = '0;
    logic [23:0]   period = '0;
    logic [AW:0]   num_entries = '0;
    logic [15:0]   repeat_count = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          aborted_o;
    logic [7:0]    state_out;

    pulse_seq_sched_if bus();

    pulse_seq_sched #(.AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .tbl_we_i       (tbl_we),
        .tbl_addr_i     (tbl_addr),
        .tbl_wdata_i    (tbl_wdata),
        .period_i       (period),
        .num_entries_i  (num_entries),
        .repeat_count_i (repeat_count),
        .start_i        (start),
        .abort_i        (abort),
        .bus            (bus),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .aborted_o      (aborted_o),
        .state_out_o    (state_out)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_count = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          last_done_cyc = 0;
    int          host_viol = 0;
    bit          host_chk = 1'b0;
    logic [31:0] exp_q [$];
    logic [23:0] tbl_m [2**AW];
    vec_t        vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every FIFO write pops one expected word.
    always @(negedge clk) begin
        cyc++;
        if (done_o) last_done_cyc = cyc;
        if (host_chk && state_out != 8'd0 && bus.host_ready) host_viol++;
        if (bus.fifo_wr) begin
            wr_count++;
            last_wr_cyc = cyc;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("fifo_wdata", bus.fifo_wdata, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic write_tbl(input int addr, input logic [23:0] data);
        tbl_we    = 1'b1;
        tbl_addr  = addr[AW-1:0];
        tbl_wdata = data;
        tick();
        tbl_we    = 1'b0;
    endtask

    task automatic push_model(input logic [AW:0] num, input logic [15:0] rep, input logic [23:0] per);
        exp_q.push_back({8'h02, per});
        exp_q.push_back(32'h0000_0000);
        for (int p = 0; p < int'(rep); p++)
            for (int i = 0; i < int'(num); i++)
                exp_q.push_back({8'h01, tbl_m[i[AW-1:0]]});
    endtask

    task automatic wait_writes(input int base, input int n, input int budget, input string tag);
        for (int i = 0; i < budget && (wr_count - base) < n; i++) sample();
        check({tag, "_reach"}, wr_count - base, n);
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic ab, output logic bz,
                             output logic [7:0] st);
        seen = 1'b0;
        ab   = 1'bx;
        bz   = 1'bx;
        st   = 'x;
        for (int i = 0; i < budget && !seen; i++) begin
            sample();
            if (done_o) begin
                seen = 1'b1;
                ab   = aborted_o;
                bz   = busy_o;
                st   = state_out;
            end
        end
    endtask

    task automatic run_seq(input vec_t v, input string tag);
        int         base;
        bit         seen;
        logic       ab;
        logic       bz;
        logic [7:0] st;
        push_model(v.num, v.rep, v.period);
        num_entries  = v.num;
        repeat_count = v.rep;
        period       = v.period;
        base         = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        sample();
        check({tag, "_busy"}, busy_o, 1'b1);
        check({tag, "_state_period"}, state_out, 8'd1);
        wait_done(300, seen, ab, bz, st);
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_aborted"}, ab, 1'b0);
        check({tag, "_busy_at_done"}, bz, 1'b0);
        check({tag, "_state_finish"}, st, 8'd4);
        tick();
        check({tag, "_done_one_cycle"}, done_o, 1'b0);
        check({tag, "_writes"}, wr_count - base, v.exp_words);
        check({tag, "_done_latency"}, last_done_cyc - last_wr_cyc, 1);
        check({tag, "_sb_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int         base;
        bit         seen;
        logic       ab;
        logic       bz;
        logic [7:0] st;

        vecs[0] = '{num: 5'd2,  rep: 16'd2, period: 24'd100,    exp_words: 6};
        vecs[1] = '{num: 5'd0,  rep: 16'd2, period: 24'd100,    exp_words: 2};
        vecs[2] = '{num: 5'd2,  rep: 16'd0, period: 24'h123456, exp_words: 2};
        vecs[3] = '{num: 5'd16, rep: 16'd1, period: 24'hFFFFFF, exp_words: 18};
        vecs[4] = '{num: 5'd1,  rep: 16'd3, period: 24'h000001, exp_words: 5};
        vecs[5] = '{num: 5'd3,  rep: 16'd2, period: 24'd7,      exp_words: 8};

        bus.host_cmd   = '0;
        bus.host_valid = 1'b0;
        bus.fifo_full  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_aborted", aborted_o, 1'b0);
        check("rst_fifo_wr", bus.fifo_wr, 1'b0);
        check("rst_fifo_wdata", bus.fifo_wdata, 32'h0);
        check("rst_state", state_out, 8'd0);
        rst = 1'b1;
        tick();

        // Host word forwarded while idle, written one cycle after acceptance
        bus.host_cmd   = 32'h0300_0000;
        bus.host_valid = 1'b1;
        exp_q.push_back(32'h0300_0000);
        base = wr_count;
        sample();
        check("host_ready_idle", bus.host_ready, 1'b1);
        check("host_no_early_wr", bus.fifo_wr, 1'b0);
        tick();
        bus.host_valid = 1'b0;
        sample();
        check("host_wr_latency", bus.fifo_wr, 1'b1);
        check("host_ready_while_pend", bus.host_ready, 1'b0);
        tick();
        check("host_wr_count", wr_count - base, 1);
        check("host_sb_drained", exp_q.size(), 0);

        // Table load
        for (int i = 0; i < 2**AW; i++) begin
            tbl_m[i] = (i == 0) ? 24'h000305 : (i == 1) ? 24'h000002 : {16'(i * 257), 8'(i * 3 + 1)};
            write_tbl(i, tbl_m[i]);
        end

        // start together with abort in idle: start ignored
        base = wr_count;
        num_entries = 5'd2; repeat_count = 16'd2; period = 24'd100;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        sample();
        check("sa_busy", busy_o, 1'b0);
        check("sa_state", state_out, 8'd0);
        tick();
        check("sa_no_write", wr_count - base, 0);

        // Abort after the 10th write of a long sequence; a table write while busy is ignored
        exp_q.push_back({8'h02, 24'h000050});
        exp_q.push_back(32'h0);
        for (int i = 0; i < 9; i++) exp_q.push_back({8'h01, tbl_m[i]});
        num_entries = 5'd16; repeat_count = 16'd1000; period = 24'h000050;
        base = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        write_tbl(0, 24'hABCDEF);
        wait_writes(base, 10, 100, "abort");
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(50, seen, ab, bz, st);
        check("abort_done_seen", seen, 1'b1);
        check("abort_aborted", ab, 1'b1);
        check("abort_busy", bz, 1'b0);
        tick();
        check("abort_wr_max11", 32'((wr_count - base) <= 11), 32'd1);
        check("abort_done_latency", last_done_cyc - last_wr_cyc, 1);
        exp_q.delete();

        // Table-driven sequence runs
        for (int v = 0; v < 6; v++) run_seq(vecs[v], $sformatf("vec%0d", v));

        // FIFO full for 5 cycles during the third word
        push_model(5'd2, 16'd2, 24'd100);
        num_entries = 5'd2; repeat_count = 16'd2; period = 24'd100;
        base = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_writes(base, 2, 20, "stall");
        tick();
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            check("stall_fifo_wr", bus.fifo_wr, 1'b0);
            check("stall_wdata", bus.fifo_wdata, 32'h0100_0305);
            tick();
        end
        bus.fifo_full = 1'b0;
        wait_done(50, seen, ab, bz, st);
        check("stall_done_seen", seen, 1'b1);
        check("stall_aborted", ab, 1'b0);
        tick();
        check("stall_writes", wr_count - base, 6);
        check("stall_sb_drained", exp_q.size(), 0);
        exp_q.delete();

        // host_ready held low for a whole sequence while a host word waits
        host_viol      = 0;
        host_chk       = 1'b1;
        bus.host_cmd   = 32'h0300_0000;
        bus.host_valid = 1'b1;
        run_seq(vecs[0], "host_busy");
        bus.host_valid = 1'b0;
        host_chk       = 1'b0;
        check("host_ready_busy", host_viol, 0);

        // Asynchronous reset during the ISSUE stall, then a full rerun
        push_model(5'd2, 16'd2, 24'd100);
        num_entries = 5'd2; repeat_count = 16'd2; period = 24'd100;
        base = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_writes(base, 2, 20, "rstmid");
        tick();
        bus.fifo_full = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_fifo_wr", bus.fifo_wr, 1'b0);
        check("rstmid_busy", busy_o, 1'b0);
        check("rstmid_state", state_out, 8'd0);
        exp_q.delete();
        bus.fifo_full = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        run_seq(vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
